// File: rtl/wb_bus_arbiter_pkg.sv
// Shared definitions for the Wishbone bus arbiter: FSM encoding, bus widths
// and the index-width helper used by the arbiter and its round-robin picker.
package wb_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    S_CPU   = 2'd0,
    S_DRAIN = 2'd1,
    S_DMA   = 2'd2,
    S_REL   = 2'd3
  } arb_state_t;

  localparam int ADR_W = 16;
  localparam int DAT_W = 16;
  localparam int SEL_W = 2;

  // A single DMA master still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from rr, wrapping modulo NDMA.
module wb_rr_pick
  import wb_bus_arbiter_pkg::*;
#(
  parameter int NDMA = 2,
  localparam int IDX_W = idx_w(NDMA)
) (
  input  logic [NDMA-1:0]  req,
  input  logic [IDX_W-1:0] rr,
  output logic [IDX_W-1:0] k,
  output logic             vld
);

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    k   = '0;
    vld = 1'b0;
    for (int i = NDMA - 1; i >= 0; i--) begin
      if (req[(int'(rr) + i) % NDMA]) begin
        k   = IDX_W'((int'(rr) + i) % NDMA);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Wishbone bus arbiter between the 1801VM1 CPU and NDMA DMA masters, with
// CPU dwell guarantee, drain handshake, round-robin DMA selection and watchdog.
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int NDMA    = 2,
  parameter int MIN_CPU = 4,
  parameter int TMO_CYC = 255
) (
  input  logic                  clk_p,
  input  logic                  dclo,
  input  logic                  cpu_cyc_i,
  input  logic                  cpu_stb_i,
  input  logic                  cpu_we_i,
  input  logic [SEL_W-1:0]      cpu_sel_i,
  input  logic [ADR_W-1:0]      cpu_adr_i,
  input  logic [DAT_W-1:0]      cpu_dat_i,
  output logic                  cpu_gnt_o,
  output logic                  cpu_ack_o,
  input  logic [NDMA-1:0]       dma_req_i,
  output logic [NDMA-1:0]       dma_gnt_o,
  input  logic [NDMA-1:0]       dma_cyc_i,
  input  logic [NDMA-1:0]       dma_stb_i,
  input  logic [NDMA-1:0]       dma_we_i,
  input  logic [SEL_W*NDMA-1:0] dma_sel_i,
  input  logic [ADR_W*NDMA-1:0] dma_adr_i,
  input  logic [DAT_W*NDMA-1:0] dma_dat_i,
  output logic [NDMA-1:0]       dma_ack_o,
  output logic                  bus_cyc_o,
  output logic                  bus_stb_o,
  output logic                  bus_we_o,
  output logic [SEL_W-1:0]      bus_sel_o,
  output logic [ADR_W-1:0]      bus_adr_o,
  output logic [DAT_W-1:0]      bus_dat_o,
  input  logic                  bus_ack_i,
  output logic                  tmo_o
);

  localparam int IDX_W = idx_w(NDMA);
  localparam int DW_W  = (MIN_CPU > 0) ? $clog2(MIN_CPU + 1) : 1;
  localparam int WD_W  = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             tmo_q, tmo_d;
  logic [IDX_W-1:0] pick_k;
  logic             pick_vld;
  logic [IDX_W-1:0] rr_inc;

  wb_rr_pick #(.NDMA(NDMA)) u_pick (
    .req (dma_req_i),
    .rr  (rr_q),
    .k   (pick_k),
    .vld (pick_vld)
  );

  assign rr_inc = (k_q == IDX_W'(NDMA - 1)) ? '0 : k_q + IDX_W'(1);

  // ---- state register ----
  always_ff @(posedge clk_p or posedge dclo) begin
    if (dclo) begin
      state_q <= S_CPU;
      k_q     <= '0;
      rr_q    <= '0;
      dwell_q <= '0;
      wdog_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rr_q    <= rr_d;
      dwell_q <= dwell_d;
      wdog_q  <= wdog_d;
      tmo_q   <= tmo_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rr_d    = rr_q;
    dwell_d = dwell_q;
    wdog_d  = wdog_q;
    tmo_d   = 1'b0;
    case (state_q)
      S_CPU: begin
        if (dwell_q < DW_W'(MIN_CPU)) dwell_d = dwell_q + DW_W'(1);
        if (dwell_q >= DW_W'(MIN_CPU) && |dma_req_i) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Grant is already low here, so a low cyc means the CPU is truly idle.
        if (!cpu_cyc_i) begin
          if (pick_vld) begin
            state_d = S_DMA;
            k_d     = pick_k;
            wdog_d  = '0;
          end else begin
            state_d = S_CPU;
            dwell_d = '0;
          end
        end
      end
      S_DMA: begin
        if (!dma_req_i[k_q] && !dma_cyc_i[k_q]) begin
          state_d = S_REL;
          rr_d    = rr_inc;
        end else if (bus_ack_i) begin
          wdog_d = '0;
        end else if (bus_stb_o) begin
          if (wdog_q == WD_W'(TMO_CYC - 1)) begin
            state_d = S_REL;
            rr_d    = rr_inc;
            tmo_d   = 1'b1;
            wdog_d  = '0;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
        end
      end
      S_REL: begin
        state_d = S_CPU;
        dwell_d = '0;
      end
      default: state_d = S_CPU;
    endcase
  end

  // ---- grants, bus mux and ack routing ----
  always_comb begin
    cpu_gnt_o = (state_q == S_CPU);
    cpu_ack_o = 1'b0;
    dma_gnt_o = '0;
    dma_ack_o = '0;
    bus_cyc_o = 1'b0;
    bus_stb_o = 1'b0;
    bus_we_o  = 1'b0;
    bus_sel_o = '0;
    bus_adr_o = '0;
    bus_dat_o = '0;
    case (state_q)
      S_CPU, S_DRAIN: begin
        bus_cyc_o = cpu_cyc_i;
        bus_stb_o = cpu_stb_i;
        bus_we_o  = cpu_we_i;
        bus_sel_o = cpu_sel_i;
        bus_adr_o = cpu_adr_i;
        bus_dat_o = cpu_dat_i;
        cpu_ack_o = bus_ack_i;
      end
      S_DMA: begin
        dma_gnt_o[k_q] = 1'b1;
        dma_ack_o[k_q] = bus_ack_i;
        bus_cyc_o      = dma_cyc_i[k_q];
        bus_stb_o      = dma_stb_i[k_q];
        bus_we_o       = dma_we_i[k_q];
        bus_sel_o      = dma_sel_i[int'(k_q)*SEL_W +: SEL_W];
        bus_adr_o      = dma_adr_i[int'(k_q)*ADR_W +: ADR_W];
        bus_dat_o      = dma_dat_i[int'(k_q)*DAT_W +: DAT_W];
      end
      default: ;
    endcase
  end

  assign tmo_o = tmo_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: reset, CPU pass-through, DMA grant,
// drain handshake, watchdog abort, round-robin fairness and async reset.
module tb_wb_bus_arbiter;

  logic        clk_p = 1'b0;
  logic        dclo;
  logic        cpu_cyc_i, cpu_stb_i, cpu_we_i;
  logic [1:0]  cpu_sel_i;
  logic [15:0] cpu_adr_i, cpu_dat_i;
  logic        cpu_gnt_o, cpu_ack_o;
  logic [1:0]  dma_req_i, dma_gnt_o, dma_cyc_i, dma_stb_i, dma_we_i, dma_ack_o;
  logic [3:0]  dma_sel_i;
  logic [31:0] dma_adr_i, dma_dat_i;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [1:0]  bus_sel_o;
  logic [15:0] bus_adr_o, bus_dat_o;
  logic        bus_ack_i;
  logic        tmo_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_p = ~clk_p;

  wb_bus_arbiter #(.NDMA(2), .MIN_CPU(4), .TMO_CYC(255)) dut (
    .clk_p(clk_p), .dclo(dclo),
    .cpu_cyc_i(cpu_cyc_i), .cpu_stb_i(cpu_stb_i), .cpu_we_i(cpu_we_i),
    .cpu_sel_i(cpu_sel_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
    .cpu_gnt_o(cpu_gnt_o), .cpu_ack_o(cpu_ack_o),
    .dma_req_i(dma_req_i), .dma_gnt_o(dma_gnt_o),
    .dma_cyc_i(dma_cyc_i), .dma_stb_i(dma_stb_i), .dma_we_i(dma_we_i),
    .dma_sel_i(dma_sel_i), .dma_adr_i(dma_adr_i), .dma_dat_i(dma_dat_i),
    .dma_ack_o(dma_ack_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_sel_o(bus_sel_o), .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o),
    .bus_ack_i(bus_ack_i), .tmo_o(tmo_o)
  );

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic test_reset();
    dclo = 1'b1;
    #2;
    n_chk++; if (cpu_gnt_o !== 1'b1) $display("FAIL rst_cpu_gnt: got %b want 1", cpu_gnt_o); else n_pass++;
    n_chk++; if (dma_gnt_o !== 2'b00) $display("FAIL rst_dma_gnt: got %b want 00", dma_gnt_o); else n_pass++;
    n_chk++; if (tmo_o !== 1'b0) $display("FAIL rst_tmo: got %b want 0", tmo_o); else n_pass++;
    tick();
    dclo = 1'b0;
  endtask

  task automatic test_cpu_idle();
    cpu_adr_i = 16'o177716; cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; bus_ack_i = 1'b1;
    #1;
    n_chk++; if (bus_adr_o !== 16'o177716) $display("FAIL cpu_adr_mux: got %o want 177716", bus_adr_o); else n_pass++;
    n_chk++; if (cpu_ack_o !== 1'b1) $display("FAIL cpu_ack_route: got %b want 1", cpu_ack_o); else n_pass++;
    n_chk++; if (dma_ack_o !== 2'b00) $display("FAIL cpu_dma_ack_quiet: got %b want 00", dma_ack_o); else n_pass++;
    bus_ack_i = 1'b0; cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0;
  endtask

  task automatic test_dma_grant();
    repeat (4) tick();
    dma_req_i = 2'b01; dma_cyc_i = 2'b01;
    #1;
    n_chk++; if (cpu_gnt_o !== 1'b1) $display("FAIL req_no_edge_yet: got %b want 1", cpu_gnt_o); else n_pass++;
    tick();
    n_chk++; if (cpu_gnt_o !== 1'b0) $display("FAIL drain_cpu_gnt: got %b want 0", cpu_gnt_o); else n_pass++;
    n_chk++; if (dma_gnt_o !== 2'b00) $display("FAIL drain_dma_gnt: got %b want 00", dma_gnt_o); else n_pass++;
    tick();
    n_chk++; if (dma_gnt_o !== 2'b01) $display("FAIL grant_dma0: got %b want 01", dma_gnt_o); else n_pass++;
    n_chk++; if (bus_adr_o !== 16'o001000) $display("FAIL dma0_adr_mux: got %o want 001000", bus_adr_o); else n_pass++;
    dma_stb_i = 2'b01; bus_ack_i = 1'b1;
    #1;
    n_chk++; if (dma_ack_o !== 2'b01) $display("FAIL dma0_ack_route: got %b want 01", dma_ack_o); else n_pass++;
    n_chk++; if (cpu_ack_o !== 1'b0) $display("FAIL dma0_cpu_ack_quiet: got %b want 0", cpu_ack_o); else n_pass++;
    bus_ack_i = 1'b0; dma_req_i = 2'b00; dma_cyc_i = 2'b00; dma_stb_i = 2'b00;
    tick();
    n_chk++; if (dma_gnt_o !== 2'b00 || cpu_gnt_o !== 1'b0) $display("FAIL rel_gnts: got cpu %b dma %b want 0 00", cpu_gnt_o, dma_gnt_o); else n_pass++;
    n_chk++; if (bus_adr_o !== 16'h0000) $display("FAIL rel_bus_zero: got %o want 0", bus_adr_o); else n_pass++;
    tick();
    n_chk++; if (cpu_gnt_o !== 1'b1) $display("FAIL rel_to_cpu: got %b want 1", cpu_gnt_o); else n_pass++;
  endtask

  task automatic test_drain();
    dma_req_i = 2'b01; cpu_cyc_i = 1'b1;
    repeat (4) tick();
    n_chk++; if (cpu_gnt_o !== 1'b1) $display("FAIL dwell_hold: got %b want 1", cpu_gnt_o); else n_pass++;
    tick();
    n_chk++; if (cpu_gnt_o !== 1'b0) $display("FAIL dwell_done: got %b want 0", cpu_gnt_o); else n_pass++;
    repeat (5) tick();
    n_chk++; if (dma_gnt_o !== 2'b00) $display("FAIL drain_hold: got %b want 00", dma_gnt_o); else n_pass++;
    bus_ack_i = 1'b1;
    #1;
    n_chk++; if (cpu_ack_o !== 1'b1) $display("FAIL drain_cpu_ack: got %b want 1", cpu_ack_o); else n_pass++;
    bus_ack_i = 1'b0; cpu_cyc_i = 1'b0;
    tick();
    n_chk++; if (dma_gnt_o !== 2'b01) $display("FAIL drain_grant: got %b want 01", dma_gnt_o); else n_pass++;
    dma_req_i = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    dma_req_i = 2'b10; dma_cyc_i = 2'b10; dma_stb_i = 2'b10;
    repeat (6) tick();
    n_chk++; if (dma_gnt_o !== 2'b10) $display("FAIL grant_dma1: got %b want 10", dma_gnt_o); else n_pass++;
    n_chk++; if (bus_dat_o !== 16'hB0B1) $display("FAIL dma1_dat_mux: got %h want b0b1", bus_dat_o); else n_pass++;
    repeat (100) tick();
    bus_ack_i = 1'b1;
    #1;
    n_chk++; if (dma_ack_o !== 2'b10 || cpu_ack_o !== 1'b0) $display("FAIL dma1_ack_route: got dma %b cpu %b want 10 0", dma_ack_o, cpu_ack_o); else n_pass++;
    tick();
    bus_ack_i = 1'b0;
    repeat (254) tick();
    n_chk++; if (dma_gnt_o !== 2'b10 || tmo_o !== 1'b0) $display("FAIL wdog_early: got gnt %b tmo %b want 10 0", dma_gnt_o, tmo_o); else n_pass++;
    tick();
    n_chk++; if (tmo_o !== 1'b1) $display("FAIL wdog_pulse: got %b want 1", tmo_o); else n_pass++;
    n_chk++; if (dma_gnt_o !== 2'b00 || cpu_gnt_o !== 1'b0) $display("FAIL wdog_rel: got cpu %b dma %b want 0 00", cpu_gnt_o, dma_gnt_o); else n_pass++;
    tick();
    n_chk++; if (tmo_o !== 1'b0 || cpu_gnt_o !== 1'b1) $display("FAIL wdog_after: got tmo %b cpu %b want 0 1", tmo_o, cpu_gnt_o); else n_pass++;
    dma_req_i = 2'b00; dma_cyc_i = 2'b00; dma_stb_i = 2'b00;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    dma_req_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      repeat (4) tick();
      n_chk++; if (cpu_gnt_o !== 1'b1) $display("FAIL rr_dwell_%0d: got %b want 1", i, cpu_gnt_o); else n_pass++;
      tick();
      tick();
      n_chk++; if (dma_gnt_o !== exp) $display("FAIL rr_grant_%0d: got %b want %b", i, dma_gnt_o, exp); else n_pass++;
      dma_req_i = ~exp;
      tick();
      n_chk++; if (dma_gnt_o !== 2'b00 || cpu_gnt_o !== 1'b0) $display("FAIL rr_rel_%0d: got cpu %b dma %b want 0 00", i, cpu_gnt_o, dma_gnt_o); else n_pass++;
      dma_req_i = 2'b11;
      tick();
    end
  endtask

  task automatic test_dclo();
    repeat (6) tick();
    n_chk++; if (dma_gnt_o !== 2'b10) $display("FAIL pre_dclo_grant: got %b want 10", dma_gnt_o); else n_pass++;
    #2;
    dclo = 1'b1;
    #1;
    n_chk++; if (dma_gnt_o !== 2'b00 || cpu_gnt_o !== 1'b1) $display("FAIL dclo_async: got cpu %b dma %b want 1 00", cpu_gnt_o, dma_gnt_o); else n_pass++;
    tick();
    dclo = 1'b0;
    repeat (6) tick();
    n_chk++; if (dma_gnt_o !== 2'b01) $display("FAIL dclo_rr_zero: got %b want 01", dma_gnt_o); else n_pass++;
  endtask

  initial begin
    dclo = 1'b1;
    cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; cpu_we_i = 1'b0; cpu_sel_i = 2'b11;
    cpu_adr_i = 16'h0000; cpu_dat_i = 16'h1234;
    dma_req_i = 2'b00; dma_cyc_i = 2'b00; dma_stb_i = 2'b00; dma_we_i = 2'b10;
    dma_sel_i = 4'b1101;
    dma_adr_i = {16'o002000, 16'o001000};
    dma_dat_i = {16'hB0B1, 16'hA0A1};
    bus_ack_i = 1'b0;
    test_reset();
    test_cpu_idle();
    test_dma_grant();
    test_drain();
    test_timeout();
    test_round_robin();
    test_dclo();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
